key_sw_conditioner: RTL

- Input-conditioning stage directly upstream of the lab7_soc PIO inputs.
- Takes the raw asynchronous board switches (8) and push-buttons KEY[3:2] and runs them through a 2-flop synchronizer and a per-channel counter debouncer.
- Drives clean levels into sw_wire_export, key_2_wire_export and key_3_wire_export.
- Also produces one-cycle press/release pulses for fabric-side logic.

---
 rtl/key_sw_conditioner_pkg.sv | 12 +
 rtl/key_sw_conditioner_debounce_chan.sv | 71 +++++++
 rtl/key_sw_conditioner.sv | 59 +++++
 3 files changed

// File: rtl/key_sw_conditioner_pkg.sv
// Shared constants for the lab7 board I/O conditioning path: debounce
// lengths for silicon and simulation, and the idle level of each input kind.
package lab7_io_pkg;

  localparam int DEBOUNCE_CYCLES_50MHZ = 500000;
  localparam int SIM_DEBOUNCE_CYCLES   = 4;

  // Keys idle released (high); slide switches idle off (low).
  localparam logic KEY_IDLE = 1'b1;
  localparam logic SW_IDLE  = 1'b0;

endpackage

// File: rtl/key_sw_conditioner_debounce_chan.sv
// One input bit: 2-flop synchronizer followed by a stable-value + counter
// debouncer that emits registered one-cycle rise/fall pulses on acceptance.
module debounce_chan #(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter int   CNT_W           = 24,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             rise_q;
  logic             rise_d;
  logic             fall_q;
  logic             fall_d;

  // Counter runs only while the synchronized input disagrees with the
  // accepted level; any return to agreement clears it (glitch rejection).
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = ~stable_q;
        rise_d   = ~stable_q;
        fall_d   = stable_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q  <= RESET_VAL;
      sync2_q  <= RESET_VAL;
      stable_q <= RESET_VAL;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign level_o = stable_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/key_sw_conditioner.sv
// Board switch/key conditioner feeding the lab7_soc PIOs: one debounce
// channel per switch and per key, plus press/release pulses for the keys.
module key_sw_conditioner
  import lab7_io_pkg::*;
#(
  parameter int NUM_SW          = 8,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
  parameter int CNT_W           = 24
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [NUM_SW-1:0] sw_raw,
  input  logic [1:0]        key_raw_n,
  output logic [NUM_SW-1:0] sw_clean,
  output logic              key_2_clean_n,
  output logic              key_3_clean_n,
  output logic [1:0]        key_press,
  output logic [1:0]        key_release
);

  logic [NUM_SW-1:0] unused_sw_rise;
  logic [NUM_SW-1:0] unused_sw_fall;
  logic [1:0]        key_level_s;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .RESET_VAL       (SW_IDLE)
    ) u_chan (
      .clk_i   (clk_clk),
      .rst_ni  (reset_reset_n),
      .raw_i   (sw_raw[i]),
      .level_o (sw_clean[i]),
      .rise_o  (unused_sw_rise[i]),
      .fall_o  (unused_sw_fall[i])
    );
  end

  // Keys are active-low, so a falling level is a press and a rising one a release.
  for (genvar k = 0; k < 2; k++) begin : g_key
    debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .RESET_VAL       (KEY_IDLE)
    ) u_chan (
      .clk_i   (clk_clk),
      .rst_ni  (reset_reset_n),
      .raw_i   (key_raw_n[k]),
      .level_o (key_level_s[k]),
      .rise_o  (key_release[k]),
      .fall_o  (key_press[k])
    );
  end

  assign key_2_clean_n = key_level_s[0];
  assign key_3_clean_n = key_level_s[1];

endmodule
